// File: rtl/simon_sequencer_if.sv
// Simon sequencer signal bundle: player controls, pattern memory port and
// display/status outputs. The sequencer is the master side.
interface simon_sequencer_if;
    logic       start;
    logic       tick;
    logic [1:0] rand_color;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic [1:0] mem_out;
    logic [2:0] mem_address;
    logic [1:0] mem_data_in;
    logic       mem_write_en;
    logic       show_valid;
    logic [1:0] show_color;
    logic [2:0] level;
    logic       busy;
    logic       win;
    logic       lose;

    modport master (
        input  start, tick, rand_color, btn_valid, btn_color, mem_out,
        output mem_address, mem_data_in, mem_write_en,
        output show_valid, show_color, level, busy, win, lose
    );

    modport slave (
        output start, tick, rand_color, btn_valid, btn_color, mem_out,
        input  mem_address, mem_data_in, mem_write_en,
        input  show_valid, show_color, level, busy, win, lose
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random color pattern in external memory,
// plays it back paced by tick, then checks the player's button presses.
module simon_sequencer #(
    parameter int TICKS_ON  = 1,
    parameter int TICKS_OFF = 1
) (
    input  logic              clk,
    input  logic              reset,
    simon_sequencer_if.master bus
);
    localparam int TMAX = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(TICKS_ON - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(TICKS_OFF - 1);

    typedef enum logic [2:0] {
        IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      level;
    logic [2:0]      idx;
    logic [CW-1:0]   cnt;
    logic [1:0]      data;
    logic            hit;
    logic            on_done;
    logic            off_done;
    logic            last;
    logic            write_en;
    logic            show;
    logic            busy;
    logic            win;
    logic            lose;
    logic [2:0]      address;

    assign hit      = bus.btn_color == bus.mem_out;
    assign on_done  = bus.tick && (cnt == ON_LAST);
    assign off_done = bus.tick && (cnt == OFF_LAST);
    assign last     = idx == level;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, WIN, LOSE: if (bus.start) state_nx = ADD;
            ADD:             state_nx = PLAY_ON;
            PLAY_ON:         if (on_done) state_nx = PLAY_OFF;
            PLAY_OFF: begin
                if (off_done) state_nx = last ? WAIT_IN : PLAY_ON;
            end
            WAIT_IN: begin
                if (bus.btn_valid) begin
                    if (!hit)      state_nx = LOSE;
                    else if (last) state_nx = (level == 3'd7) ? WIN : ADD;
                end
            end
            default:         state_nx = IDLE;
        endcase
    end

    // Datapath registers only move on the events their state listens to.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 3'd0;
            idx   <= 3'd0;
            cnt   <= '0;
            data  <= 2'd0;
        end else begin
            unique case (state)
                IDLE, WIN, LOSE: begin
                    if (bus.start) begin
                        level <= 3'd0;
                        idx   <= 3'd0;
                        data  <= bus.rand_color;
                    end
                end
                ADD: begin
                    idx <= 3'd0;
                    cnt <= '0;
                end
                PLAY_ON: begin
                    if (bus.tick) cnt <= on_done ? '0 : cnt + 1'b1;
                end
                PLAY_OFF: begin
                    if (off_done) begin
                        cnt <= '0;
                        idx <= last ? 3'd0 : idx + 3'd1;
                    end else if (bus.tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (bus.btn_valid && hit) begin
                        if (!last) begin
                            idx <= idx + 3'd1;
                        end else if (level != 3'd7) begin
                            level <= level + 3'd1;
                            data  <= bus.rand_color;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        write_en = 1'b0;
        address  = idx;
        show     = 1'b0;
        busy     = 1'b1;
        win      = 1'b0;
        lose     = 1'b0;
        unique case (state)
            ADD: begin
                write_en = 1'b1;
                address  = level;
            end
            PLAY_ON: show = 1'b1;
            IDLE:    busy = 1'b0;
            WIN: begin
                busy = 1'b0;
                win  = 1'b1;
            end
            LOSE: begin
                busy = 1'b0;
                lose = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_write_en = write_en;
    assign bus.mem_address  = address;
    assign bus.mem_data_in  = data;
    assign bus.show_valid   = show;
    assign bus.show_color   = show ? bus.mem_out : 2'd0;
    assign bus.level        = level;
    assign bus.busy         = busy;
    assign bus.win          = win;
    assign bus.lose         = lose;
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: directed vector table, pattern-queue game model
// with random pacing, and a slow-pacing instance.
module tb_simon_sequencer;
    localparam int ON_A  = 1;
    localparam int OFF_A = 1;
    localparam int ON_B  = 3;
    localparam int OFF_B = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simon_sequencer_if ia();
    simon_sequencer_if ib();

    simon_sequencer #(.TICKS_ON(ON_A), .TICKS_OFF(OFF_A)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.master)
    );
    simon_sequencer #(.TICKS_ON(ON_B), .TICKS_OFF(OFF_B)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.master)
    );

    logic [1:0] mem_a [8];
    logic [1:0] mem_b [8];
    always @(posedge clk) begin
        if (ia.mem_write_en) mem_a[ia.mem_address] <= ia.mem_data_in;
        if (ib.mem_write_en) mem_b[ib.mem_address] <= ib.mem_data_in;
    end
    assign ia.mem_out = mem_a[ia.mem_address];
    assign ib.mem_out = mem_b[ib.mem_address];

    int writes_a = 0;
    always @(negedge clk) if (ia.mem_write_en) writes_a++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ia.start = 0; ia.tick = 0; ia.btn_valid = 0;
        ib.start = 0; ib.tick = 0; ib.btn_valid = 0;
    endtask

    function automatic logic [14:0] snap_a();
        return {ia.mem_write_en, ia.mem_address, ia.mem_data_in,
                ia.show_valid, ia.show_color, ia.level,
                ia.busy, ia.win, ia.lose};
    endfunction

    typedef struct {
        int         start, tick, rc, bv, bc;
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t v(int s, int t, int rc, int bv, int bc,
                               int we, int ad, int di, int sv, int sc,
                               int lv, int bu, int wi, int lo);
        vec_t r;
        r.start = s; r.tick = t; r.rc = rc; r.bv = bv; r.bc = bc;
        r.exp = {1'(we), 3'(ad), 2'(di), 1'(sv), 2'(sc), 3'(lv),
                 1'(bu), 1'(wi), 1'(lo)};
        return r;
    endfunction

    // Reference model state: the pattern the game should have stored.
    logic [1:0] pat[$];
    int         force_rc[$];

    task automatic next_rc();
        if (force_rc.size() > 0) ia.rand_color = 2'(force_rc.pop_front());
        else                     ia.rand_color = 2'($urandom_range(0, 3));
        pat.push_back(ia.rand_color);
    endtask

    task automatic idle_play(input int sv, input int sc, input int ad);
        int n;
        int exp;
        n   = $urandom_range(0, 2);
        exp = (sv << 7) | (sc << 5) | (ad << 2) | int'(pat[pat.size()-1]);
        chk("play", int'({ia.show_valid, ia.show_color, ia.mem_address,
                          ia.mem_data_in}), exp);
        repeat (n) begin
            ia.btn_valid  = 1'($urandom_range(0, 1));
            ia.btn_color  = 2'($urandom_range(0, 3));
            ia.start      = 1'($urandom_range(0, 1));
            ia.rand_color = 2'($urandom_range(0, 3));
            cyc();
            clr();
            chk("play_hold", int'({ia.show_valid, ia.show_color,
                                   ia.mem_address, ia.mem_data_in}), exp);
        end
    endtask

    task automatic idle_wait(input int ad);
        int n;
        n = $urandom_range(0, 2);
        chk("wait", int'({ia.busy, ia.lose, ia.show_valid, ia.mem_address}),
            (1 << 5) | ad);
        repeat (n) begin
            ia.tick  = 1'($urandom_range(0, 1));
            ia.start = 1'($urandom_range(0, 1));
            cyc();
            clr();
            chk("wait_hold", int'({ia.busy, ia.lose, ia.show_valid,
                                   ia.mem_address}), (1 << 5) | ad);
        end
    endtask

    task automatic game(input int fail_lvl, input int fail_idx,
                        input int wrong, input bit abort);
        pat.delete();
        writes_a = 0;
        next_rc();
        ia.start = 1;
        cyc();
        clr();
        for (int lv = 0; lv < 8; lv++) begin
            chk("add", int'({ia.mem_write_en, ia.mem_address,
                             ia.mem_data_in, ia.level, ia.busy}),
                (1 << 9) | (lv << 6) | (int'(pat[lv]) << 4) | (lv << 1) | 1);
            cyc();
            for (int i = 0; i <= lv; i++) begin
                for (int k = 0; k < ON_A; k++) begin
                    idle_play(1, int'(pat[i]), i);
                    if (abort && lv == fail_lvl && i == fail_idx) begin
                        reset = 1;
                        cyc();
                        reset = 0;
                        chk("abort_reset", int'(snap_a()), 0);
                        ia.tick = 1;
                        ia.btn_valid = 1;
                        ia.btn_color = 2'($urandom_range(0, 3));
                        cyc();
                        clr();
                        chk("idle_ignore", int'(snap_a()), 0);
                        return;
                    end
                    ia.tick = 1;
                    cyc();
                    clr();
                end
                for (int k = 0; k < OFF_A; k++) begin
                    idle_play(0, 0, i);
                    ia.tick = 1;
                    cyc();
                    clr();
                end
            end
            for (int i = 0; i <= lv; i++) begin
                idle_wait(i);
                ia.btn_valid = 1;
                ia.btn_color = pat[i];
                if (lv == fail_lvl && i == fail_idx && !abort) begin
                    ia.btn_color = (wrong >= 0) ? 2'(wrong)
                                 : 2'((int'(pat[i]) + $urandom_range(1, 3)) % 4);
                    cyc();
                    clr();
                    chk("lose", int'({ia.lose, ia.win, ia.busy, ia.level}),
                        (1 << 5) | lv);
                    ia.tick = 1;
                    ia.btn_valid = 1;
                    cyc();
                    clr();
                    chk("lose_hold", int'({ia.lose, ia.busy, ia.mem_write_en,
                                           ia.show_valid, ia.level}),
                        (1 << 6) | lv);
                    return;
                end
                if (i == lv && lv < 7) next_rc();
                cyc();
                clr();
                if (i < lv) chk("wait_next", int'(ia.mem_address), i + 1);
            end
        end
        chk("win", int'({ia.win, ia.lose, ia.busy, ia.level}), (1 << 5) | 7);
        chk("win_writes", writes_a, 8);
        chk("win_outputs", int'({ia.mem_write_en, ia.show_valid,
                                 ia.show_color}), 0);
    endtask

    task automatic count_b(input logic target, output int n);
        n = 0;
        while (ib.show_valid != target && n < 8) begin
            ib.tick = 1;
            cyc();
            clr();
            cyc();
            n++;
        end
    endtask

    vec_t tbl[18];

    initial begin
        int n;
        ia.start = 0; ia.tick = 0; ia.rand_color = 0;
        ia.btn_valid = 0; ia.btn_color = 0;
        ib.start = 0; ib.tick = 0; ib.rand_color = 0;
        ib.btn_valid = 0; ib.btn_color = 0;
        reset = 1;

        //          s t rc bv bc  we ad di sv sc lv bu wi lo
        tbl[0]  = v(1,0,2, 0,0,   1, 0, 2, 0, 0, 0, 1, 0, 0);
        tbl[1]  = v(0,0,0, 0,0,   0, 0, 2, 1, 2, 0, 1, 0, 0);
        tbl[2]  = v(1,0,3, 0,0,   0, 0, 2, 1, 2, 0, 1, 0, 0);
        tbl[3]  = v(0,0,0, 1,0,   0, 0, 2, 1, 2, 0, 1, 0, 0);
        tbl[4]  = v(0,1,0, 0,0,   0, 0, 2, 0, 0, 0, 1, 0, 0);
        tbl[5]  = v(0,0,0, 0,0,   0, 0, 2, 0, 0, 0, 1, 0, 0);
        tbl[6]  = v(0,1,0, 0,0,   0, 0, 2, 0, 0, 0, 1, 0, 0);
        tbl[7]  = v(0,1,0, 0,0,   0, 0, 2, 0, 0, 0, 1, 0, 0);
        tbl[8]  = v(0,0,1, 1,2,   1, 1, 1, 0, 0, 1, 1, 0, 0);
        tbl[9]  = v(0,0,0, 0,0,   0, 0, 1, 1, 2, 1, 1, 0, 0);
        tbl[10] = v(0,1,0, 0,0,   0, 0, 1, 0, 0, 1, 1, 0, 0);
        tbl[11] = v(0,1,0, 0,0,   0, 1, 1, 1, 1, 1, 1, 0, 0);
        tbl[12] = v(0,1,0, 0,0,   0, 1, 1, 0, 0, 1, 1, 0, 0);
        tbl[13] = v(0,1,0, 0,0,   0, 0, 1, 0, 0, 1, 1, 0, 0);
        tbl[14] = v(0,0,0, 1,2,   0, 1, 1, 0, 0, 1, 1, 0, 0);
        tbl[15] = v(0,0,0, 1,0,   0, 1, 1, 0, 0, 1, 0, 0, 1);
        tbl[16] = v(0,1,0, 1,1,   0, 1, 1, 0, 0, 1, 0, 0, 1);
        tbl[17] = v(1,0,0, 0,0,   1, 0, 0, 0, 0, 0, 1, 0, 0);

        cyc();
        cyc();
        chk("reset_state", int'(snap_a()), 0);
        reset = 0;

        for (int r = 0; r < 18; r++) begin
            ia.start      = 1'(tbl[r].start);
            ia.tick       = 1'(tbl[r].tick);
            ia.rand_color = 2'(tbl[r].rc);
            ia.btn_valid  = 1'(tbl[r].bv);
            ia.btn_color  = 2'(tbl[r].bc);
            cyc();
            clr();
            chk($sformatf("vec%0d", r), int'(snap_a()), int'(tbl[r].exp));
        end

        reset = 1;
        cyc();
        reset = 0;
        chk("reset_mid_add", int'(snap_a()), 0);

        // Pattern {1,3,0}; second press wrong at level 2.
        force_rc = '{1, 3, 0};
        game(2, 1, 2, 1'b0);
        force_rc.delete();

        game(-1, -1, -1, 1'b0);
        game(3, 1, -1, 1'b1);

        for (int g = 0; g < 6; g++) begin
            int fl;
            fl = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) game(-1, -1, -1, 1'b0);
            else game(fl, $urandom_range(0, fl), -1, 1'b0);
        end

        // Slow-paced instance: 3 ticks shown, 2 ticks of gap.
        reset = 1;
        cyc();
        reset = 0;
        ib.start = 1;
        ib.rand_color = 1;
        cyc();
        clr();
        chk("b_add", int'({ib.mem_write_en, ib.mem_address, ib.mem_data_in}),
            (1 << 5) | 1);
        cyc();
        ib.start = 1;
        ib.rand_color = 2;
        cyc();
        clr();
        chk("b_start_ignored", int'({ib.show_valid, ib.show_color,
                                     ib.mem_data_in, ib.mem_write_en}),
            (1 << 5) | (1 << 3) | (1 << 1));
        count_b(1'b0, n);
        chk("b_on_ticks0", n, ON_B);
        ib.tick = 1;
        cyc();
        clr();
        chk("b_gap_mid", int'({ib.show_valid, ib.busy, ib.mem_write_en}), 2);
        ib.tick = 1;
        cyc();
        clr();
        ib.btn_valid = 1;
        ib.btn_color = 1;
        ib.rand_color = 3;
        cyc();
        clr();
        chk("b_add1", int'({ib.mem_write_en, ib.mem_address, ib.mem_data_in,
                            ib.level}), (1 << 8) | (1 << 5) | (3 << 3) | 1);
        cyc();
        chk("b_show0", int'({ib.show_valid, ib.show_color}), 5);
        count_b(1'b0, n);
        chk("b_on_ticks1", n, ON_B);
        count_b(1'b1, n);
        chk("b_off_ticks", n, OFF_B);
        chk("b_show1", int'({ib.show_valid, ib.show_color, ib.mem_address}),
            (1 << 5) | (3 << 3) | 1);
        count_b(1'b0, n);
        chk("b_on_ticks2", n, ON_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter TICKS_ON, default 1, SHALL set the number of tick pulses a playback color is shown.
REQ-002 Parameter TICKS_OFF, default 1, SHALL set the number of tick pulses of blank gap after each playback color.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a new game.
REQ-006 tick  input  1  one-cycle pacing pulse from the external rate divider.
REQ-007 rand_color  input  2  free-running random color source.
REQ-008 btn_valid  input  1  one-cycle strobe: player pressed a button.
REQ-009 btn_color  input  2  color of the pressed button, valid with btn_valid.
REQ-010 mem_out  input  2  read data from the pattern memory (combinational from mem_address).
REQ-011 mem_address  output  3  pattern memory address.
REQ-012 mem_data_in  output  2  pattern memory write data.
REQ-013 mem_write_en  output  1  pattern memory write enable; memory reads while low.
REQ-014 show_valid  output  1  high while a playback color is displayed.
REQ-015 show_color  output  2  color being displayed; SHALL equal mem_out while show_valid is high, 0 otherwise.
REQ-016 level  output  3  current level index (pattern length minus one).
REQ-017 busy  output  1  high in every state except IDLE, WIN and LOSE.
REQ-018 win  output  1  high while in WIN.
REQ-019 lose  output  1  high while in LOSE.

Function
REQ-020 States SHALL be IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE; the block SHALL hold a level register (3 bits), an index register idx (3 bits) and a tick counter.
REQ-021 IDLE/WIN/LOSE + start -> ADD, with level<=0, idx<=0, and mem_data_in<=rand_color sampled that cycle; start SHALL be ignored in all other states.
REQ-022 ADD SHALL last exactly one cycle with mem_write_en=1 and mem_address=level, then -> PLAY_ON with idx<=0 and tick counter<=0.
REQ-023 mem_write_en SHALL be 1 only in ADD; in all other states mem_address SHALL equal idx.
REQ-024 PLAY_ON: show_valid=1; each tick increments the counter; on the TICKS_ON-th tick -> PLAY_OFF, counter<=0.
REQ-025 PLAY_OFF: show_valid=0; on the TICKS_OFF-th tick: if idx==level -> WAIT_IN with idx<=0, else idx<=idx+1 -> PLAY_ON, counter<=0.
REQ-026 WAIT_IN + btn_valid: if btn_color!=mem_out -> LOSE.
REQ-027 WAIT_IN + btn_valid with match and idx<level -> idx<=idx+1, remain in WAIT_IN.
REQ-028 WAIT_IN + btn_valid with match and idx==level: if level==7 -> WIN, else level<=level+1, mem_data_in<=rand_color, -> ADD.
REQ-029 btn_valid outside WAIT_IN and tick outside PLAY_ON/PLAY_OFF SHALL be ignored, with no effect on any register.
REQ-030 Level SHALL never wrap; the maximum pattern length is 8 entries (addresses 0..7).
REQ-031 WIN and LOSE SHALL hold level, with all memory and display outputs inactive, until start or reset.

Reset
REQ-032 reset SHALL take priority over every input, in any state including mid-playback or mid-write.
REQ-033 The cycle after reset is sampled high: state=IDLE, level=0, idx=0, counter=0, mem_address=0, mem_data_in=0, mem_write_en=0, show_valid=0, show_color=0, busy=0, win=0, lose=0.
REQ-034 Pattern memory contents SHALL NOT be cleared by reset; every game rewrites each entry before reading it.

Verification
REQ-035 reset, start with rand_color=2 -> one cycle of mem_write_en=1, addr 0, data 2; then show_valid=1 with show_color=2 until 1 tick; then gap of 1 tick; then WAIT_IN, busy=1.
REQ-036 Level 0 pattern {2}, btn 2 -> ADD at addr 1 with new rand_color; playback shows addr 0 then addr 1 in order, with show_valid low for one tick between them.
REQ-037 Level 2 pattern {1,3,0}, buttons 1 then 2 -> lose=1 on the cycle after the second strobe, busy=0, level stays 2.
REQ-038 Correct input through level 7 -> win=1, level=7, exactly 8 write cycles total, no address wrap.
REQ-039 reset asserted during PLAY_ON with level=3 -> next cycle IDLE with all outputs at their reset values; btn_valid and tick pulses while in IDLE -> no change.
REQ-040 TICKS_ON=3, TICKS_OFF=2 -> show_valid high across exactly 3 ticks and low across exactly 2 ticks per entry; start pulsed during playback -> ignored.
